// File: rtl/cci_rd_req_arbiter_if.sv
// Bundle of the requester-side, MPF c0 Tx and c0 Rx signals shared by the
// read-request arbiter and its environment.
//
// Handshake: a requester offers a request by raising req_valid[i] with
// stable req_addr/req_tag; the request is taken on a rising clk edge where
// req_valid[i] & req_ready[i] are both 1. req_ready is one-hot or zero and
// may depend combinationally on req_valid. The c0 Tx side has no ready:
// c0_tx_almfull only stops new grants. Responses (c0 Rx and rsp_*) carry no
// backpressure and must be consumed in the cycle they are valid.
interface cci_rd_req_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 8,
  parameter int ADDR_W = 42
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ-1:0]        req_ready;
  logic                    c0_tx_valid;
  logic [ADDR_W-1:0]       c0_tx_addr;
  logic [15:0]             c0_tx_mdata;
  logic                    c0_tx_almfull;
  logic                    c0_rx_rdvalid;
  logic [15:0]             c0_rx_mdata;
  logic [511:0]            c0_rx_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [TAG_W-1:0]        rsp_tag;
  logic [511:0]            rsp_data;

  // Arbiter view.
  modport slave (
    input  req_valid, req_addr, req_tag, c0_tx_almfull,
           c0_rx_rdvalid, c0_rx_mdata, c0_rx_data,
    output req_ready, c0_tx_valid, c0_tx_addr, c0_tx_mdata,
           rsp_valid, rsp_tag, rsp_data
  );

  // Requester / MPF view.
  modport master (
    output req_valid, req_addr, req_tag, c0_tx_almfull,
           c0_rx_rdvalid, c0_rx_mdata, c0_rx_data,
    input  req_ready, c0_tx_valid, c0_tx_addr, c0_tx_mdata,
           rsp_valid, rsp_tag, rsp_data
  );
endinterface

// File: rtl/cci_rd_req_arbiter.sv
// Round-robin arbiter sharing the MPF c0 read-request channel among N_REQ
// requesters. The requester ID travels in mdata so responses can be steered
// back; a per-requester credit counter bounds in-flight reads.
module cci_rd_req_arbiter #(
  parameter int N_REQ           = 4,
  parameter int TAG_W           = 8,
  parameter int ADDR_W          = 42,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cci_rd_req_arbiter_if.slave   bus,
  output logic                  idle,
  output logic                  err_unexpected_rsp
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Elaboration-time parameter sanity.
  if (TAG_W + ID_W > 16) begin : g_bad_mdata
    $error("cci_rd_req_arbiter: TAG_W + clog2(N_REQ) must not exceed 16");
  end
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("cci_rd_req_arbiter: N_REQ must be in 2..16");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max
    $error("cci_rd_req_arbiter: MAX_OUTSTANDING must be in 1..255");
  end

  logic [CNT_W-1:0] cnt      [N_REQ];
  logic [CNT_W-1:0] cnt_next [N_REQ];
  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic [15:0]      tx_mdata_next;
  logic [ID_W-1:0]  rx_id;
  logic [N_REQ-1:0] rx_hit;
  logic             rx_ok;
  logic             cnt_zero_next;

  // A requester may compete only while it still holds a credit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = bus.req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Round-robin pick: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    if (!bus.c0_tx_almfull) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!grant_any && elig[idx]) begin
          grant_any  = 1'b1;
          grant_id   = ID_W'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;

  // mdata carries {zero pad, requester ID, requester tag}.
  always_comb begin
    tx_mdata_next                   = '0;
    tx_mdata_next[TAG_W-1:0]        = bus.req_tag[grant_id*TAG_W +: TAG_W];
    tx_mdata_next[TAG_W +: ID_W]    = grant_id;
  end

  // A response is accepted only for an ID that has reads in flight; anything
  // else (out-of-range ID or zero credit used) is flagged and dropped.
  assign rx_id = bus.c0_rx_mdata[TAG_W +: ID_W];

  always_comb begin
    rx_hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rx_hit[i] = bus.c0_rx_rdvalid && (rx_id == ID_W'(i)) && (cnt[i] != '0);
    end
  end

  assign rx_ok = |rx_hit;

  // Credit update: grant adds, accepted response subtracts, both cancel.
  always_comb begin
    cnt_zero_next = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_next[i] = cnt[i];
      case ({grant[i], rx_hit[i]})
        2'b10:   cnt_next[i] = cnt[i] + CNT_W'(1);
        2'b01:   cnt_next[i] = cnt[i] - CNT_W'(1);
        default: cnt_next[i] = cnt[i];
      endcase
      if (cnt_next[i] != '0) cnt_zero_next = 1'b0;
    end
  end

  // Credit counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Round-robin pointer moves just past the winner; holds with no grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Registered c0 Tx stage; address/mdata hold when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.c0_tx_valid <= 1'b0;
      bus.c0_tx_addr  <= '0;
      bus.c0_tx_mdata <= '0;
    end else begin
      bus.c0_tx_valid <= grant_any;
      if (grant_any) begin
        bus.c0_tx_addr  <= bus.req_addr[grant_id*ADDR_W +: ADDR_W];
        bus.c0_tx_mdata <= tx_mdata_next;
      end
    end
  end

  // Registered response steering; tag/data hold between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_tag   <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= rx_hit;
      if (rx_ok) begin
        bus.rsp_tag  <= bus.c0_rx_mdata[TAG_W-1:0];
        bus.rsp_data <= bus.c0_rx_data;
      end
    end
  end

  // Sticky error for responses nobody is waiting for.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_unexpected_rsp <= 1'b0;
    end else if (bus.c0_rx_rdvalid && !rx_ok) begin
      err_unexpected_rsp <= 1'b1;
    end
  end

  // idle reflects the registered state it is launched alongside: no credit
  // in use, no Tx being presented and no response being presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle <= 1'b1;
    end else begin
      idle <= cnt_zero_next && !grant_any && !rx_ok;
    end
  end

endmodule

// File: tb/tb_cci_rd_req_arbiter.sv
// Bench for cci_rd_req_arbiter: directed phases plus a random phase, all
// checked against a transaction-level model (list of in-flight reads).
module tb_cci_rd_req_arbiter;

  localparam int N    = 4;
  localparam int TW   = 8;
  localparam int AW   = 42;
  localparam int MAXO = 2;

  logic clk;
  logic reset_n;
  logic idle;
  logic err_unexpected_rsp;

  cci_rd_req_arbiter_if #(.N_REQ(N), .TAG_W(TW), .ADDR_W(AW)) bus ();

  cci_rd_req_arbiter #(
    .N_REQ(N), .TAG_W(TW), .ADDR_W(AW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .bus                (bus.slave),
    .idle               (idle),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model: every in-flight read as its mdata word.
  logic [15:0]    exp_q[$];
  int             m_ptr;
  logic           m_err;
  logic           e_tx_valid;
  logic [AW-1:0]  e_tx_addr;
  logic [15:0]    e_tx_mdata;
  logic [N-1:0]   e_rsp_valid;
  logic [TW-1:0]  e_rsp_tag;
  logic [511:0]   e_rsp_data;
  logic           e_idle;
  logic [AW-1:0]  cur_addr [N];
  logic [TW-1:0]  cur_tag  [N];
  logic           force_tag_en;
  logic [TW-1:0]  force_tag;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int id_of(input logic [15:0] m);
    return int'(m[TW +: 2]);
  endfunction

  function automatic int in_flight(input int id);
    int n;
    n = 0;
    foreach (exp_q[k]) if (id_of(exp_q[k]) == id) n++;
    return n;
  endfunction

  task automatic check_regs();
    chk("c0_tx_valid", 512'(bus.c0_tx_valid), 512'(e_tx_valid));
    chk("c0_tx_addr", 512'(bus.c0_tx_addr), 512'(e_tx_addr));
    chk("c0_tx_mdata", 512'(bus.c0_tx_mdata), 512'(e_tx_mdata));
    chk("rsp_valid", 512'(bus.rsp_valid), 512'(e_rsp_valid));
    chk("rsp_tag", 512'(bus.rsp_tag), 512'(e_rsp_tag));
    chk("rsp_data", bus.rsp_data, e_rsp_data);
    chk("idle", 512'(idle), 512'(e_idle));
    chk("err_unexpected_rsp", 512'(err_unexpected_rsp), 512'(m_err));
  endtask

  // One clock: drive inputs, check the grant, advance the model, check regs.
  task automatic step(input logic [N-1:0] v, input logic af, input logic rv,
                      input logic [15:0] rm);
    logic [511:0] rd;
    logic [N-1:0] e_ready;
    logic [15:0]  m;
    int g, j, id;
    for (int w = 0; w < 16; w++) rd[w*32 +: 32] = $urandom;
    for (int i = 0; i < N; i++) begin
      cur_addr[i] = AW'({$urandom, $urandom});
      cur_tag[i]  = force_tag_en ? force_tag : TW'($urandom);
      bus.req_addr[i*AW +: AW] = cur_addr[i];
      bus.req_tag[i*TW +: TW]  = cur_tag[i];
    end
    bus.req_valid     = v;
    bus.c0_tx_almfull = af;
    bus.c0_rx_rdvalid = rv;
    bus.c0_rx_mdata   = rm;
    bus.c0_rx_data    = rd;
    #1;
    // Who should win this cycle.
    g = -1;
    if (!af) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && v[j] && in_flight(j) < MAXO) g = j;
      end
    end
    e_ready = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", 512'(bus.req_ready), 512'(e_ready));
    // Response against reads in flight before this edge.
    e_rsp_valid = '0;
    if (rv) begin
      id = id_of(rm);
      if (id < N && in_flight(id) > 0) begin
        for (int k = 0; k < exp_q.size(); k++) begin
          if (id_of(exp_q[k]) == id) begin
            exp_q.delete(k);
            break;
          end
        end
        e_rsp_valid = N'(1 << id);
        e_rsp_tag   = rm[TW-1:0];
        e_rsp_data  = rd;
      end else begin
        m_err = 1'b1;
      end
    end
    // Request issue.
    e_tx_valid = (g >= 0);
    if (g >= 0) begin
      m = '0;
      m[TW-1:0]  = cur_tag[g];
      m[TW +: 2] = 2'(g);
      e_tx_addr  = cur_addr[g];
      e_tx_mdata = m;
      exp_q.push_back(m);
      m_ptr = (g + 1) % N;
    end
    e_idle = (exp_q.size() == 0) && !e_tx_valid && (e_rsp_valid == '0);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  // Return every in-flight read in random order with no new requests.
  task automatic drain();
    int k;
    while (exp_q.size() > 0) begin
      k = $urandom_range(0, exp_q.size() - 1);
      step('0, 1'b0, 1'b1, exp_q[k]);
    end
  endtask

  initial begin
    int k;
    logic [15:0] rm;
    force_tag_en      = 1'b0;
    force_tag         = '0;
    bus.req_valid     = '0;
    bus.req_addr      = '0;
    bus.req_tag       = '0;
    bus.c0_tx_almfull = 1'b0;
    bus.c0_rx_rdvalid = 1'b0;
    bus.c0_rx_mdata   = '0;
    bus.c0_rx_data    = '0;
    reset_n           = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset values.
    m_ptr = 0; m_err = 1'b0;
    e_tx_valid = 1'b0; e_tx_addr = '0; e_tx_mdata = '0;
    e_rsp_valid = '0; e_rsp_tag = '0; e_rsp_data = '0; e_idle = 1'b1;
    check_regs();
    chk("req_ready_reset", 512'(bus.req_ready), 512'(0));

    // Quiet after reset.
    repeat (10) step('0, 1'b0, 1'b0, '0);

    // Round-robin with all requesters busy and immediate returns.
    for (int c = 0; c < 16; c++) begin
      if (exp_q.size() > 0) step('1, 1'b0, 1'b1, exp_q[0]);
      else step('1, 1'b0, 1'b0, '0);
    end
    drain();

    // Credit limit on requester 1.
    repeat (5) step(4'b0010, 1'b0, 1'b0, '0);
    step(4'b0010, 1'b0, 1'b1, exp_q[0]);
    repeat (2) step(4'b0010, 1'b0, 1'b0, '0);
    drain();

    // Backpressure: one request already in the pipe, then nothing.
    step('1, 1'b0, 1'b0, '0);
    repeat (20) step('1, 1'b1, 1'b0, '0);
    repeat (4) step('1, 1'b0, 1'b0, '0);
    drain();

    // Response steering with a known tag.
    force_tag_en = 1'b1;
    force_tag    = 8'hA5;
    step(4'b0100, 1'b0, 1'b0, '0);
    force_tag_en = 1'b0;
    step('0, 1'b0, 1'b0, '0);
    step('0, 1'b0, 1'b1, 16'h02A5);
    chk("steer_rsp_valid", 512'(bus.rsp_valid), 512'(4'b0100));
    chk("steer_rsp_tag", 512'(bus.rsp_tag), 512'(8'hA5));
    step('0, 1'b0, 1'b0, '0);
    chk("steer_idle", 512'(idle), 512'(1));

    // Unexpected response for requester 3.
    step('0, 1'b0, 1'b1, 16'h0311);
    chk("unexpected_no_rsp", 512'(bus.rsp_valid), 512'(0));
    repeat (3) step('0, 1'b0, 1'b0, '0);
    chk("err_sticky", 512'(err_unexpected_rsp), 512'(1));

    // Grant and response for requester 0 in the same cycle.
    step(4'b0001, 1'b0, 1'b0, '0);
    step(4'b0001, 1'b0, 1'b1, exp_q[0]);
    step(4'b0001, 1'b0, 1'b0, '0);
    step(4'b0001, 1'b0, 1'b0, '0);
    drain();

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      rm = '0;
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        k  = $urandom_range(0, exp_q.size() - 1);
        rm = exp_q[k];
        step(N'($urandom), ($urandom_range(0, 3) == 0), 1'b1, rm);
      end else if ($urandom_range(0, 15) == 0) begin
        rm = 16'($urandom_range(0, 1023));
        step(N'($urandom), ($urandom_range(0, 3) == 0), 1'b1, rm);
      end else begin
        step(N'($urandom), ($urandom_range(0, 3) == 0), 1'b0, '0);
      end
    end
    drain();
    step('0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
